// File: rtl/control_pipe_if.sv
// ID-stage request and pipeline control/status bundle for control_pipe.
// slave = the control pipe itself, master = the core (or bench) driving ID.
interface control_pipe_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [6:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              ex_branch_taken;

    logic              pc_write;
    logic              ifid_write;
    logic              id_illegal;
    logic              ex_alusrc;
    logic [1:0]        ex_aluop;
    logic              ex_branch;
    logic              ex_jump;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_read;
    logic              mem_write;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_regwrite;
    logic              wb_memtoreg;
    logic [REG_AW-1:0] wb_rd;
    logic [CNT_W-1:0]  bubble_cnt;

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        output pc_write, ifid_write, id_illegal,
        output ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_rd,
        output mem_read, mem_write, mem_rd,
        output wb_regwrite, wb_memtoreg, wb_rd, bubble_cnt
    );

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        input  pc_write, ifid_write, id_illegal,
        input  ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_rd,
        input  mem_read, mem_write, mem_rd,
        input  wb_regwrite, wb_memtoreg, wb_rd, bubble_cnt
    );
endinterface

// File: rtl/control_pipe.sv
// RV32I control pipeline: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use bubble insertion, branch flush and a saturating bubble counter.
module control_pipe #(
    parameter int REG_AW      = 5,
    parameter bit ENABLE_JUMP = 1'b0,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          reset,
    control_pipe_if.slave bus
);
    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_IARI = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Bundle bit positions: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUop[1:0]}
    localparam int B_ALUSRC   = 7;
    localparam int B_MEMTOREG = 6;
    localparam int B_REGWRITE = 5;
    localparam int B_MEMREAD  = 4;
    localparam int B_MEMWRITE = 3;
    localparam int B_BRANCH   = 2;

    logic [7:0]        dec_ctrl;
    logic              dec_jump;
    logic              dec_legal;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              hazard;
    logic              flush;
    logic              stall;

    logic [7:0]        idex_ctrl_q,  idex_ctrl_d;
    logic              idex_jump_q,  idex_jump_d;
    logic [REG_AW-1:0] idex_rd_q,    idex_rd_d;
    logic [3:0]        exmem_ctrl_q, exmem_ctrl_d;
    logic [REG_AW-1:0] exmem_rd_q,   exmem_rd_d;
    logic [1:0]        memwb_ctrl_q, memwb_ctrl_d;
    logic [REG_AW-1:0] memwb_rd_q,   memwb_rd_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        dec_ctrl  = 8'b0;
        dec_jump  = 1'b0;
        dec_legal = 1'b1;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        unique case (bus.id_opcode)
            OP_NOP:  ;
            OP_LW:   begin dec_ctrl = 8'b1111_0000; uses_rs1 = 1'b1; end
            OP_SW:   begin dec_ctrl = 8'b1000_1000; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_RTYP: begin dec_ctrl = 8'b0010_0010; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_IARI: begin dec_ctrl = 8'b1010_0011; uses_rs1 = 1'b1; end
            OP_BR:   begin dec_ctrl = 8'b0000_0101; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_JAL: begin
                if (ENABLE_JUMP) begin
                    dec_ctrl = 8'b0010_0000;
                    dec_jump = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OP_JALR: begin
                if (ENABLE_JUMP) begin
                    dec_ctrl = 8'b1010_0000;
                    dec_jump = 1'b1;
                    uses_rs1 = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            default: dec_legal = 1'b0;
        endcase
        // An empty ID slot decodes to nothing and is never illegal.
        if (!bus.id_valid) begin
            dec_ctrl  = 8'b0;
            dec_jump  = 1'b0;
            dec_legal = 1'b1;
            uses_rs1  = 1'b0;
            uses_rs2  = 1'b0;
        end
    end

    assign flush  = bus.ex_branch_taken;
    assign hazard = bus.id_valid && idex_ctrl_q[B_MEMREAD] && (idex_rd_q != '0) &&
                    ((uses_rs1 && (idex_rd_q == bus.id_rs1)) ||
                     (uses_rs2 && (idex_rd_q == bus.id_rs2)));
    assign stall  = hazard && !flush;

    assign bus.pc_write   = !stall;
    assign bus.ifid_write = !stall;
    assign bus.id_illegal = bus.id_valid && !dec_legal && !flush;

    always_comb begin
        idex_ctrl_d = dec_ctrl;
        idex_jump_d = dec_jump;
        idex_rd_d   = (bus.id_valid && dec_legal) ? bus.id_rd : '0;
        // x0 is hard-wired, so a write to it is dropped here once.
        if (bus.id_rd == '0) begin
            idex_ctrl_d[B_REGWRITE] = 1'b0;
        end
        if (flush || hazard) begin
            idex_ctrl_d = 8'b0;
            idex_jump_d = 1'b0;
            idex_rd_d   = '0;
        end

        exmem_ctrl_d = {idex_ctrl_q[B_MEMTOREG], idex_ctrl_q[B_REGWRITE],
                        idex_ctrl_q[B_MEMREAD],  idex_ctrl_q[B_MEMWRITE]};
        exmem_rd_d   = idex_rd_q;
        memwb_ctrl_d = exmem_ctrl_q[3:2];
        memwb_rd_d   = exmem_rd_q;

        bubble_cnt_d = bubble_cnt_q;
        if (stall && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_ctrl_q  <= '0;
            idex_jump_q  <= 1'b0;
            idex_rd_q    <= '0;
            exmem_ctrl_q <= '0;
            exmem_rd_q   <= '0;
            memwb_ctrl_q <= '0;
            memwb_rd_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            idex_ctrl_q  <= idex_ctrl_d;
            idex_jump_q  <= idex_jump_d;
            idex_rd_q    <= idex_rd_d;
            exmem_ctrl_q <= exmem_ctrl_d;
            exmem_rd_q   <= exmem_rd_d;
            memwb_ctrl_q <= memwb_ctrl_d;
            memwb_rd_q   <= memwb_rd_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.ex_alusrc   = idex_ctrl_q[B_ALUSRC];
    assign bus.ex_aluop    = idex_ctrl_q[1:0];
    assign bus.ex_branch   = idex_ctrl_q[B_BRANCH];
    assign bus.ex_jump     = idex_jump_q;
    assign bus.ex_rd       = idex_rd_q;
    assign bus.mem_read    = exmem_ctrl_q[1];
    assign bus.mem_write   = exmem_ctrl_q[0];
    assign bus.mem_rd      = exmem_rd_q;
    assign bus.wb_regwrite = memwb_ctrl_q[0];
    assign bus.wb_memtoreg = memwb_ctrl_q[1];
    assign bus.wb_rd       = memwb_rd_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: u0 default, u1 with jump decode, u2 with a
// 2-bit bubble counter, all fed the same ID-stage stimulus.
module tb_control_pipe;
    logic       clk;
    logic       rst;
    logic       s_valid;
    logic [6:0] s_op;
    logic [4:0] s_rs1, s_rs2, s_rd;
    logic       s_br;
    int         n_pass;
    int         n_total;

    control_pipe_if #(.REG_AW(5), .CNT_W(16)) if0 ();
    control_pipe_if #(.REG_AW(5), .CNT_W(16)) if1 ();
    control_pipe_if #(.REG_AW(5), .CNT_W(2))  if2 ();

    assign if0.id_valid = s_valid;  assign if1.id_valid = s_valid;  assign if2.id_valid = s_valid;
    assign if0.id_opcode = s_op;    assign if1.id_opcode = s_op;    assign if2.id_opcode = s_op;
    assign if0.id_rs1 = s_rs1;      assign if1.id_rs1 = s_rs1;      assign if2.id_rs1 = s_rs1;
    assign if0.id_rs2 = s_rs2;      assign if1.id_rs2 = s_rs2;      assign if2.id_rs2 = s_rs2;
    assign if0.id_rd = s_rd;        assign if1.id_rd = s_rd;        assign if2.id_rd = s_rd;
    assign if0.ex_branch_taken = s_br;
    assign if1.ex_branch_taken = s_br;
    assign if2.ex_branch_taken = s_br;

    control_pipe #(.REG_AW(5), .ENABLE_JUMP(1'b0), .CNT_W(16)) u0 (.clk(clk), .reset(rst), .bus(if0));
    control_pipe #(.REG_AW(5), .ENABLE_JUMP(1'b1), .CNT_W(16)) u1 (.clk(clk), .reset(rst), .bus(if1));
    control_pipe #(.REG_AW(5), .ENABLE_JUMP(1'b0), .CNT_W(2))  u2 (.clk(clk), .reset(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        s_valid = v; s_op = op; s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_br = 1'b0;
        $display("txn t=%0t valid=%0b op=%07b rs1=%0d rs2=%0d rd=%0d", $time, v, op, rs1, rs2, rd);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick(); tick();
        n_total++; if ({if0.ex_alusrc, if0.ex_aluop, if0.ex_branch, if0.ex_jump, if0.ex_rd} !== 10'd0) $display("FAIL reset_ex got %0h want 0", {if0.ex_alusrc, if0.ex_aluop, if0.ex_branch, if0.ex_jump, if0.ex_rd}); else n_pass++;
        n_total++; if ({if0.mem_read, if0.mem_write, if0.mem_rd, if0.wb_regwrite, if0.wb_memtoreg, if0.wb_rd} !== 14'd0) $display("FAIL reset_memwb got %0h want 0", {if0.mem_read, if0.mem_write, if0.mem_rd, if0.wb_regwrite, if0.wb_memtoreg, if0.wb_rd}); else n_pass++;
        n_total++; if (if0.bubble_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", if0.bubble_cnt); else n_pass++;
        n_total++; if ({if0.pc_write, if0.ifid_write} !== 2'b11) $display("FAIL reset_pcw got %0b want 11", {if0.pc_write, if0.ifid_write}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [6:0] ops [0:5] = '{7'b0000000, 7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
        logic [7:0] exp [0:5] = '{8'b00000000, 8'b11110000, 8'b10001000, 8'b00100010, 8'b10100011, 8'b00000101};
        logic [7:0] e;
        for (int i = 0; i < 6; i++) begin
            e = exp[i];
            drive(1'b1, ops[i], 5'd1, 5'd2, 5'd3);
            n_total++; if (if0.id_illegal !== 1'b0) $display("FAIL dec_illegal op=%07b got %0b want 0", ops[i], if0.id_illegal); else n_pass++;
            tick();
            n_total++; if ({if0.ex_alusrc, if0.ex_branch, if0.ex_aluop, if0.ex_jump} !== {e[7], e[2], e[1:0], 1'b0}) $display("FAIL dec_ex op=%07b got %05b want %05b", ops[i], {if0.ex_alusrc, if0.ex_branch, if0.ex_aluop, if0.ex_jump}, {e[7], e[2], e[1:0], 1'b0}); else n_pass++;
            n_total++; if (if0.ex_rd !== 5'd3) $display("FAIL dec_ex_rd op=%07b got %0d want 3", ops[i], if0.ex_rd); else n_pass++;
            drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
            tick();
            n_total++; if ({if0.mem_read, if0.mem_write, if0.mem_rd} !== {e[4], e[3], 5'd3}) $display("FAIL dec_mem op=%07b got %0h want %0h", ops[i], {if0.mem_read, if0.mem_write, if0.mem_rd}, {e[4], e[3], 5'd3}); else n_pass++;
            tick();
            n_total++; if ({if0.wb_regwrite, if0.wb_memtoreg, if0.wb_rd} !== {e[5], e[6], 5'd3}) $display("FAIL dec_wb op=%07b got %0h want %0h", ops[i], {if0.wb_regwrite, if0.wb_memtoreg, if0.wb_rd}, {e[5], e[6], 5'd3}); else n_pass++;
        end
    endtask

    task automatic test_illegal_rd0();
        drive(1'b1, 7'b1111111, 5'd1, 5'd2, 5'd4);
        n_total++; if (if0.id_illegal !== 1'b1) $display("FAIL illegal_flag got %0b want 1", if0.id_illegal); else n_pass++;
        tick();
        n_total++; if ({if0.ex_alusrc, if0.ex_aluop, if0.ex_branch, if0.ex_jump} !== 5'd0) $display("FAIL illegal_ex got %0h want 0", {if0.ex_alusrc, if0.ex_aluop, if0.ex_branch, if0.ex_jump}); else n_pass++;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        n_total++; if (if0.id_illegal !== 1'b0) $display("FAIL invalid_no_illegal got %0b want 0", if0.id_illegal); else n_pass++;
        drive(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick(); tick();
        n_total++; if (if0.wb_regwrite !== 1'b0) $display("FAIL rd0_regwrite got %0b want 0", if0.wb_regwrite); else n_pass++;
    endtask

    task automatic test_load_use();
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 7'b0110011, 5'd1, 5'd5, 5'd7);
        n_total++; if ({if0.pc_write, if0.ifid_write} !== 2'b00) $display("FAIL lu_stall got %02b want 00", {if0.pc_write, if0.ifid_write}); else n_pass++;
        tick();
        n_total++; if ({if0.ex_alusrc, if0.ex_aluop, if0.ex_branch, if0.ex_jump, if0.ex_rd} !== 10'd0) $display("FAIL lu_bubble got %0h want 0", {if0.ex_alusrc, if0.ex_aluop, if0.ex_branch, if0.ex_jump, if0.ex_rd}); else n_pass++;
        n_total++; if (if0.bubble_cnt !== 16'd1) $display("FAIL lu_cnt got %0d want 1", if0.bubble_cnt); else n_pass++;
        n_total++; if (if0.mem_read !== 1'b1) $display("FAIL lu_mem_read got %0b want 1", if0.mem_read); else n_pass++;
        n_total++; if ({if0.pc_write, if0.ifid_write} !== 2'b11) $display("FAIL lu_release got %02b want 11", {if0.pc_write, if0.ifid_write}); else n_pass++;
        tick();
        n_total++; if ({if0.ex_aluop, if0.ex_rd} !== {2'b10, 5'd7}) $display("FAIL lu_rtype_ex got %0h want %0h", {if0.ex_aluop, if0.ex_rd}, {2'b10, 5'd7}); else n_pass++;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_no_false_hazard();
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, 7'b0110011, 5'd0, 5'd2, 5'd9);
        n_total++; if (if0.pc_write !== 1'b1) $display("FAIL nfh_rd0 got %0b want 1", if0.pc_write); else n_pass++;
        tick();
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 7'b0010011, 5'd6, 5'd5, 5'd8);
        n_total++; if ({if0.pc_write, if0.ifid_write} !== 2'b11) $display("FAIL nfh_iarith got %02b want 11", {if0.pc_write, if0.ifid_write}); else n_pass++;
        tick();
        n_total++; if ({if0.ex_aluop, if0.ex_rd} !== {2'b11, 5'd8}) $display("FAIL nfh_iarith_ex got %0h want %0h", {if0.ex_aluop, if0.ex_rd}, {2'b11, 5'd8}); else n_pass++;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 7'b0110011, 5'd1, 5'd5, 5'd7);
        s_br = 1'b1;
        #1;
        n_total++; if ({if0.pc_write, if0.ifid_write} !== 2'b11) $display("FAIL flush_pcw got %02b want 11", {if0.pc_write, if0.ifid_write}); else n_pass++;
        tick();
        n_total++; if ({if0.ex_aluop, if0.ex_rd} !== 7'd0) $display("FAIL flush_ex got %0h want 0", {if0.ex_aluop, if0.ex_rd}); else n_pass++;
        n_total++; if (if0.bubble_cnt !== 16'd1) $display("FAIL flush_cnt got %0d want 1", if0.bubble_cnt); else n_pass++;
        drive(1'b1, 7'b1111111, 5'd0, 5'd0, 5'd0);
        s_br = 1'b1;
        #1;
        n_total++; if (if0.id_illegal !== 1'b0) $display("FAIL flush_illegal got %0b want 0", if0.id_illegal); else n_pass++;
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_jump();
        drive(1'b1, 7'b1101111, 5'd0, 5'd0, 5'd9);
        n_total++; if (if0.id_illegal !== 1'b1) $display("FAIL jal_off_illegal got %0b want 1", if0.id_illegal); else n_pass++;
        n_total++; if (if1.id_illegal !== 1'b0) $display("FAIL jal_on_illegal got %0b want 0", if1.id_illegal); else n_pass++;
        tick();
        n_total++; if ({if1.ex_jump, if1.ex_alusrc, if1.ex_aluop} !== 4'b1000) $display("FAIL jal_on_ex got %04b want 1000", {if1.ex_jump, if1.ex_alusrc, if1.ex_aluop}); else n_pass++;
        n_total++; if (if0.ex_jump !== 1'b0) $display("FAIL jal_off_ex got %0b want 0", if0.ex_jump); else n_pass++;
        drive(1'b1, 7'b1100111, 5'd2, 5'd0, 5'd10);
        tick();
        n_total++; if ({if1.ex_jump, if1.ex_alusrc} !== 2'b11) $display("FAIL jalr_on_ex got %02b want 11", {if1.ex_jump, if1.ex_alusrc}); else n_pass++;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        n_total++; if ({if1.wb_regwrite, if1.wb_rd} !== {1'b1, 5'd9}) $display("FAIL jal_on_wb got %0h want %0h", {if1.wb_regwrite, if1.wb_rd}, {1'b1, 5'd9}); else n_pass++;
        n_total++; if (if0.wb_regwrite !== 1'b0) $display("FAIL jal_off_wb got %0b want 0", if0.wb_regwrite); else n_pass++;
        tick();
        n_total++; if ({if1.wb_regwrite, if1.wb_rd} !== {1'b1, 5'd10}) $display("FAIL jalr_on_wb got %0h want %0h", {if1.wb_regwrite, if1.wb_rd}, {1'b1, 5'd10}); else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
            tick();
            drive(1'b1, 7'b0110011, 5'd5, 5'd0, 5'd6);
            n_total++; if (if0.pc_write !== 1'b0) $display("FAIL sat_stall%0d got %0b want 0", i, if0.pc_write); else n_pass++;
            tick(); tick();
        end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        n_total++; if (if0.bubble_cnt !== 16'd5) $display("FAIL sat_cnt16 got %0d want 5", if0.bubble_cnt); else n_pass++;
        n_total++; if (if2.bubble_cnt !== 2'd3) $display("FAIL sat_cnt2 got %0d want 3", if2.bubble_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        n_total++; if (if0.mem_read !== 1'b1) $display("FAIL rstmid_pre got %0b want 1", if0.mem_read); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if ({if0.mem_read, if0.wb_regwrite, if0.wb_memtoreg} !== 3'b000) $display("FAIL rstmid_flushed got %03b want 000", {if0.mem_read, if0.wb_regwrite, if0.wb_memtoreg}); else n_pass++;
        n_total++; if ({if0.bubble_cnt, if2.bubble_cnt} !== 18'd0) $display("FAIL rstmid_cnt got %0h want 0", {if0.bubble_cnt, if2.bubble_cnt}); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        s_valid = 1'b0; s_op = 7'd0; s_rs1 = 5'd0; s_rs2 = 5'd0; s_rd = 5'd0; s_br = 1'b0;
        test_reset();
        test_decode();
        test_illegal_rd0();
        test_load_use();
        test_no_false_hazard();
        test_flush();
        test_jump();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Pipelined successor to the single-cycle opcode decoder for the 5-stage RV32I core.
- Decodes the ID-stage opcode into the control bundle, then carries that bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles. Handles branch flush, illegal-opcode flagging, optional JAL/JALR decode and a saturating stall counter.

Parameters:
- REG_AW, 5, register-address width for rs1/rs2/rd.
- ENABLE_JUMP, 0, 1 = decode JAL (1101111) and JALR (1100111); 0 = treat them as illegal.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID-stage instruction is valid
- id_opcode  in  7  ID instruction bits [6:0]
- id_rs1  in  REG_AW  source register 1
- id_rs2  in  REG_AW  source register 2
- id_rd  in  REG_AW  destination register
- ex_branch_taken  in  1  branch resolved taken in EX; flush request
- pc_write  out  1  0 = hold PC
- ifid_write  out  1  0 = hold the IF/ID register
- id_illegal  out  1  combinational; valid, non-flushed ID opcode is not decodable
- ex_alusrc  out  1  EX-stage ALUSrc
- ex_aluop  out  2  EX-stage ALUop
- ex_branch  out  1  EX-stage Branch
- ex_jump  out  1  EX-stage jump (always 0 when ENABLE_JUMP=0)
- ex_rd  out  REG_AW  EX-stage destination
- mem_read  out  1  MEM-stage MemRead
- mem_write  out  1  MEM-stage MemWrite
- mem_rd  out  REG_AW  MEM-stage destination
- wb_regwrite  out  1  WB-stage RegWrite
- wb_memtoreg  out  1  WB-stage MemtoReg
- wb_rd  out  REG_AW  WB-stage destination
- bubble_cnt  out  CNT_W  count of inserted bubbles, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. On reset every pipeline register clears to 0: all ex_*, mem_*, wb_* outputs are 0 and bubble_cnt is 0. pc_write and ifid_write read 1 after reset.
- Decode: combinational in ID. Bundle order is {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUop}.
  - 0000000 (nop) -> 00000000
  - 0000011 (lw) -> 11110000
  - 0100011 (sw) -> 10001000
  - 0110011 (R-type) -> 00100010
  - 0010011 (I-arith) -> 10100011
  - 1100011 (branch) -> 00000101
  - ENABLE_JUMP=1, 1101111 (JAL) and 1100111 (JALR) -> RegWrite=1, jump=1. ALUSrc=1 for JALR only. ALUop=00.
  - Any other opcode -> all zeros and id_illegal=1. No latch; every path is assigned.
  - id_valid=0 -> all zeros, id_illegal=0.
- Register use:
  - uses_rs1 = lw, sw, R-type, I-arith, branch, JALR.
  - uses_rs2 = sw, R-type, branch.
- Load-use hazard:
  - hazard = id_valid & ID/EX MemRead & (ex_rd != 0) & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
  - On hazard: pc_write=0, ifid_write=0, and the ID/EX register loads a zero bundle (bubble). This is combinational and same-cycle. The stall lasts exactly 1 cycle, because the bubble removes the MemRead condition.
- Flush: ex_branch_taken=1 -> ID/EX loads a zero bundle next edge. Flush overrides hazard: pc_write=1, ifid_write=1, id_illegal=0.
- Priority: reset > flush > hazard > normal load.
- Destination handling: rd is carried alongside the bundle. RegWrite is forced to 0 in ID/EX when id_rd == 0.
- Latency: ex_* outputs are 1 cycle after ID, mem_* 2 cycles, wb_* 3 cycles. EX/MEM and MEM/WB always advance; they never stall.
- bubble_cnt: increments by 1 on each clock where a hazard bubble is inserted (flush bubbles are not counted). It holds at 2^CNT_W-1.
- Reset mid-operation: all in-flight bundles are discarded on the same edge.

Test Plan:
- Decode sweep: id_valid=1 with each legal opcode (e.g. 0110011, rd=3) -> ex_* match the table 1 cycle later, mem_* after 2 cycles, wb_regwrite=1 and wb_rd=3 after 3 cycles. Opcode 1111111 -> id_illegal=1, zero bundle.
- Load-use: lw rd=5, then R-type with rs2=5 -> pc_write=ifid_write=0 for exactly 1 cycle, a bubble appears at ex_* (all 0), bubble_cnt=1, and the R-type reaches EX on the following cycle.
- No false hazard: lw rd=0 then add rs1=0 -> no stall. lw rd=5 then I-arith with rs2 field=5, rs1=6 -> no stall.
- Flush vs hazard: hazard condition with ex_branch_taken=1 on the same cycle -> pc_write=1, ID/EX zeroed next edge, bubble_cnt unchanged.
- JAL: ENABLE_JUMP=0 -> 1101111 gives id_illegal=1. ENABLE_JUMP=1 -> ex_jump=1 and wb_regwrite=1 three cycles later.
- Reset and saturation: reset asserted with lw in MEM -> mem_read=0 after the edge. With CNT_W=2, 5 hazards -> bubble_cnt=3.
